// File: rtl/plot_arbiter.sv
// ---------------------------------------------------------------------------
// plot_arbiter
//
// Two-requester arbiter that paints one square tile of pixels into a frame
// buffer for the winning requester.  A request names a tile by column/row and
// a palette entry.  The block grants one requester, latches its tile, then
// streams 2^TILE_LOG2 x 2^TILE_LOG2 pixel writes in raster order (row-major).
// A request whose tile lies outside the grid is answered straight away with
// done+err and no writes at all.
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous, active-low reset
//   req[1:0]     plot request, bit i = requester i
//   xpos0/xpos1  tile column of requester 0 / 1
//   ypos0/ypos1  tile row of requester 0 / 1
//   color0/1     palette select of requester 0 / 1
//   vga_x        pixel column to the frame buffer
//   vga_y        pixel row to the frame buffer
//   vga_colour   pixel colour
//   vga_plot     frame-buffer write enable (high only while plotting)
//   gnt[1:0]     one-hot current owner, held through PLOT and DONE
//   done[1:0]    one-cycle completion pulse to the owner
//   err[1:0]     one-cycle pulse alongside done for an out-of-range tile
//   busy         high whenever the block is not idle
//   dbg_state    current FSM state (0 = IDLE, 1 = PLOT, 2 = DONE)
//
// Handshake: a requester raises req with its coordinates and keeps them
// stable while req is high; it drops req on the clock edge at which it
// sees done.  req is only looked at in IDLE, and the tile is latched at the
// grant, so later input changes do not affect a tile in progress.
// ---------------------------------------------------------------------------
module plot_arbiter #(
    parameter int         TILE_LOG2 = 2,
    parameter int         GRID_W    = 40,
    parameter int         GRID_H    = 30,
    parameter logic [2:0] COL0      = 3'b000,
    parameter logic [2:0] COL1      = 3'b010,
    parameter logic [2:0] COL2      = 3'b011,
    parameter logic [2:0] COL3      = 3'b100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [5:0] xpos0,
    input  logic [5:0] xpos1,
    input  logic [4:0] ypos0,
    input  logic [4:0] ypos1,
    input  logic [1:0] color0,
    input  logic [1:0] color1,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic [1:0] err,
    output logic       busy,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLOT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Grid limits widened by one bit so a full 6-bit / 5-bit coordinate can
    // be compared without wrapping.
    localparam logic [6:0] GRID_W_C = 7'(GRID_W);
    localparam logic [5:0] GRID_H_C = 6'(GRID_H);

    // Last pixel index along one tile edge.
    localparam logic [TILE_LOG2-1:0] PIX_MAX = '1;

    state_t               state;
    logic                 last_gnt;   // index of the requester granted last
    logic [5:0]           xpos_q;
    logic [4:0]           ypos_q;
    logic [1:0]           color_q;
    logic [TILE_LOG2-1:0] px;
    logic [TILE_LOG2-1:0] py;

    // ----------------------------------------------------------------------
    // Arbitration: a lone request wins; on a tie the requester that was not
    // granted last wins.  last_gnt resets to 1, so requester 0 takes the
    // first tie.
    // ----------------------------------------------------------------------
    logic       win;
    logic [5:0] win_x;
    logic [4:0] win_y;
    logic [1:0] win_c;
    logic       win_oor;
    logic [1:0] win_onehot;

    always_comb begin
        win = 1'b0;
        case (req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last_gnt;
            default: win = 1'b0;
        endcase
    end

    assign win_x      = win ? xpos1  : xpos0;
    assign win_y      = win ? ypos1  : ypos0;
    assign win_c      = win ? color1 : color0;
    assign win_onehot = win ? 2'b10  : 2'b01;
    assign win_oor    = ({1'b0, win_x} >= GRID_W_C) || ({1'b0, win_y} >= GRID_H_C);

    // ----------------------------------------------------------------------
    // Control FSM.  gnt, done and err are registered here; done and err
    // default low every cycle so they can only ever be single-cycle pulses.
    // ----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            gnt      <= 2'b00;
            done     <= 2'b00;
            err      <= 2'b00;
            last_gnt <= 1'b1;
            xpos_q   <= '0;
            ypos_q   <= '0;
            color_q  <= '0;
            px       <= '0;
            py       <= '0;
        end else begin
            done <= 2'b00;
            err  <= 2'b00;
            case (state)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        xpos_q   <= win_x;
                        ypos_q   <= win_y;
                        color_q  <= win_c;
                        last_gnt <= win;
                        gnt      <= win_onehot;
                        px       <= '0;
                        py       <= '0;
                        if (win_oor) begin
                            // Nothing to draw: answer in the very next cycle.
                            state <= S_DONE;
                            done  <= win_onehot;
                            err   <= win_onehot;
                        end else begin
                            state <= S_PLOT;
                        end
                    end
                end
                S_PLOT: begin
                    px <= px + 1'b1;
                    if (px == PIX_MAX) begin
                        py <= py + 1'b1;
                        if (py == PIX_MAX) begin
                            state <= S_DONE;
                            done  <= gnt;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    gnt   <= 2'b00;
                end
                default: begin
                    state <= S_IDLE;
                    gnt   <= 2'b00;
                end
            endcase
        end
    end

    // ----------------------------------------------------------------------
    // Pixel datapath.  Multiplying by 2^TILE_LOG2 and adding a counter that
    // is strictly below 2^TILE_LOG2 is just a concatenation, so there is no
    // carry and no overflow for any in-range tile.
    // ----------------------------------------------------------------------
    assign vga_x    = 8'({xpos_q, px});
    assign vga_y    = 7'({ypos_q, py});
    assign vga_plot = (state == S_PLOT);

    always_comb begin
        vga_colour = COL0;
        case (color_q)
            2'd0:    vga_colour = COL0;
            2'd1:    vga_colour = COL1;
            2'd2:    vga_colour = COL2;
            default: vga_colour = COL3;
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_plot_arbiter.sv
// ---------------------------------------------------------------------------
// tb_plot_arbiter
//
// Directed and random requests against plot_arbiter.  A behavioural model
// (round-robin winner, grid range test, list of tile pixels) fills an
// expected-write queue; a monitor pops it on every frame-buffer write.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// on the falling edge (monitor) or 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_plot_arbiter;

    logic       clk;
    logic       reset;
    logic [1:0] req;
    logic [5:0] xpos0, xpos1;
    logic [4:0] ypos0, ypos1;
    logic [1:0] color0, color1;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic [1:0] gnt, done, err;
    logic       busy;
    logic [1:0] dbg_state;

    plot_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .xpos0      (xpos0),
        .xpos1      (xpos1),
        .ypos0      (ypos0),
        .ypos1      (ypos1),
        .color0     (color0),
        .color1     (color1),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .gnt        (gnt),
        .done       (done),
        .err        (err),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;
    logic [17:0] exp_q[$];      // {x[7:0], y[6:0], colour[2:0]}
    logic [1:0]  exp_gnt = 2'b00;
    int          last_w = 1;    // model of the round-robin pointer

    logic [2:0] palette [4] = '{3'b000, 3'b010, 3'b011, 3'b100};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every write must be the next pixel the model predicted.
    always @(negedge clk) begin
        if (vga_plot === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {vga_x, vga_y, vga_colour}, 32'h3ffff);
            end else begin
                check("write", {vga_x, vga_y, vga_colour}, exp_q.pop_front());
                check("gnt_plot", gnt, exp_gnt);
            end
        end
    end

    // ---------------- model helpers ----------------
    function automatic int pick(input logic [1:0] r);
        int w;
        if (r == 2'b01)      w = 0;
        else if (r == 2'b10) w = 1;
        else                 w = (last_w == 1) ? 0 : 1;
        last_w = w;
        return w;
    endfunction

    task automatic push_tile(input int x, input int y, input int c);
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++)
                exp_q.push_back({8'(x * 4 + i), 7'(y * 4 + j), palette[c]});
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req0(input int x, input int y, input int c);
        xpos0 = 6'(x); ypos0 = 5'(y); color0 = 2'(c);
    endtask

    task automatic set_req1(input int x, input int y, input int c);
        xpos1 = 6'(x); ypos1 = 5'(y); color1 = 2'(c);
    endtask

    // Called 1 unit after an edge that starts an IDLE cycle with req set
    // (cycle 0).  Returns 1 unit after the edge that starts cycle 18 (or 2
    // for an out-of-range tile), with the winner's request dropped.
    task automatic serve();
        int  w, x, y, c, n;
        bit  inr, seen;
        w = pick(req);
        x = (w == 0) ? int'(xpos0)  : int'(xpos1);
        y = (w == 0) ? int'(ypos0)  : int'(ypos1);
        c = (w == 0) ? int'(color0) : int'(color1);
        inr = (x < 40) && (y < 30);
        if (inr) push_tile(x, y, c);
        exp_gnt = (w == 0) ? 2'b01 : 2'b10;
        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            // Winner's inputs change after the grant; the tile must not.
            if (n == 3) begin
                if (w == 0) set_req0($urandom_range(0, 63), $urandom_range(0, 31), $urandom_range(0, 3));
                else        set_req1($urandom_range(0, 63), $urandom_range(0, 31), $urandom_range(0, 3));
            end
            if (done !== 2'b00) seen = 1;
        end
        check("done_latency", n, inr ? 17 : 1);
        check("done", done, exp_gnt);
        check("err", err, inr ? 2'b00 : exp_gnt);
        check("gnt_done", gnt, exp_gnt);
        check("busy_done", busy, 1);
        req[w] = 1'b0;
        @(posedge clk); #1;
        check("idle_busy", busy, 0);
        check("idle_gnt", gnt, 2'b00);
        check("idle_done", done, 2'b00);
        check("writes_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        req   = 2'b00;
        set_req0(0, 0, 0);
        set_req1(0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", gnt, 2'b00);
        check("rst_done", done, 2'b00);
        check("rst_err", err, 2'b00);
        check("rst_plot", vga_plot, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Single tile, requester 0: x 8..11, y 12..15, colour 010.
        set_req0(2, 3, 1);
        req = 2'b01;
        serve();

        // Out-of-range column for requester 1.
        set_req1(40, 0, 2);
        req = 2'b10;
        serve();

        // Bottom-right tile of the grid.
        set_req0(39, 29, 3);
        req = 2'b01;
        serve();

        // Tie right after a reset: requester 0 first, then requester 1.
        reset = 1'b0;
        last_w = 1;
        #2;
        reset = 1'b1;
        @(posedge clk); #1;
        set_req0(5, 6, 2);
        set_req1(7, 8, 3);
        req = 2'b11;
        serve();
        check("tie_second_pending", req, 2'b10);
        serve();

        // Reset in the middle of a tile: writes stop, no done.
        set_req0(10, 10, 1);
        req = 2'b01;
        void'(pick(req));
        push_tile(10, 10, 1);
        exp_gnt = 2'b01;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
        req = 2'b00;
        #1;
        check("rst_mid_plot", vga_plot, 0);
        check("rst_mid_done", done, 2'b00);
        check("rst_mid_gnt", gnt, 2'b00);
        check("rst_mid_busy", busy, 0);
        exp_q.delete();
        last_w = 1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst_done", done, 2'b00);
        set_req0(1, 1, 3);
        req = 2'b01;
        serve();

        // Random traffic, including ties and out-of-range tiles.
        for (int k = 0; k < 14; k++) begin
            set_req0($urandom_range(0, 45), $urandom_range(0, 31), $urandom_range(0, 3));
            set_req1($urandom_range(0, 45), $urandom_range(0, 31), $urandom_range(0, 3));
            req = 2'($urandom_range(1, 3));
            serve();
            if (req != 2'b00) serve();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop in case something above never returns.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
